// File: rtl/receptor_diferencial_n.sv
// receptor_diferencial_n: multi-lane differential receiver with electrical-idle detection and glitch counting.
// Optional RX_SYNC_EN adds a 2-flop synchronizer on dp/dn before classification.
module receptor_diferencial_n #(
    parameter int LANES       = 4,
    parameter int IDLE_CYCLES = 4,
    parameter int EXIT_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enb,
    input  logic                   clr_err,
    input  logic [LANES-1:0]       dp,
    input  logic [LANES-1:0]       dn,
    output logic [LANES-1:0]       salida,
    output logic [LANES-1:0]       valido,
    output logic [LANES-1:0]       RxElecIdle,
    output logic [LANES*ERR_W-1:0] err_cnt
);
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic [LANES-1:0] dp_s, dn_s;
`ifdef RX_SYNC_EN
    logic [LANES-1:0] dp1_q, dp2_q, dn1_q, dn2_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp1_q <= '0;
            dp2_q <= '0;
            dn1_q <= '0;
            dn2_q <= '0;
        end else begin
            dp1_q <= dp;
            dp2_q <= dp1_q;
            dn1_q <= dn;
            dn2_q <= dn1_q;
        end
    end
    assign dp_s = dp2_q;
    assign dn_s = dn2_q;
`else
    assign dp_s = dp;
    assign dn_s = dn;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             state_q, state_d;
        logic [7:0]       run_q, run_d;
        logic             sal_q, sal_d, val_q, val_d;
        logic [ERR_W-1:0] err_q, err_d;
        logic             diff;
        assign diff = dp_s[i] ^ dn_s[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                run_q   <= '0;
                sal_q   <= 1'b0;
                val_q   <= 1'b0;
                err_q   <= '0;
            end else begin
                state_q <= state_d;
                run_q   <= run_d;
                sal_q   <= sal_d;
                val_q   <= val_d;
                err_q   <= err_d;
            end
        end

        // run_q counts valid samples in IDLE and non-differential samples in ACTIVE
        always_comb begin
            state_d = state_q;
            run_d   = run_q;
            sal_d   = sal_q;
            val_d   = 1'b0;
            err_d   = err_q;
            if (!enb) begin
                state_d = IDLE;
                run_d   = '0;
                sal_d   = 1'b0;
            end else if (state_q == IDLE) begin
                sal_d = 1'b0;
                run_d = diff ? run_q + 8'd1 : '0;
                if (diff && run_q == 8'(EXIT_CYCLES - 1)) begin
                    state_d = ACTIVE;
                    run_d   = '0;
                    sal_d   = dp_s[i];
                    val_d   = 1'b1;
                end
            end else if (diff) begin
                sal_d = dp_s[i];
                val_d = 1'b1;
                run_d = '0;
                if (run_q != '0 && err_q != '1) err_d = err_q + 1'b1;
            end else if (run_q == 8'(IDLE_CYCLES - 1)) begin
                state_d = IDLE;
                run_d   = '0;
                sal_d   = 1'b0;
            end else begin
                run_d = run_q + 8'd1;
            end
            if (clr_err) err_d = '0;
        end

        assign salida[i]                    = sal_q;
        assign valido[i]                    = val_q;
        assign RxElecIdle[i]                = (state_q == IDLE);
        assign err_cnt[i*ERR_W +: ERR_W]    = err_q;
    end
endmodule

// File: tb/tb_receptor_diferencial_n.sv
// tb_receptor_diferencial_n: directed self-checking bench for receptor_diferencial_n (default build).
module tb_receptor_diferencial_n;
    logic        clk = 1'b0;
    logic        rst, enb, clr_err;
    logic [3:0]  dp, dn;
    logic [3:0]  salida, valido, RxElecIdle;
    logic [31:0] err_cnt;
    int          passed = 0;
    int          total  = 0;

    receptor_diferencial_n #(.LANES(4), .IDLE_CYCLES(4), .EXIT_CYCLES(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .enb(enb), .clr_err(clr_err), .dp(dp), .dn(dn),
        .salida(salida), .valido(valido), .RxElecIdle(RxElecIdle), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] p, input logic [3:0] n);
        dp = p;
        dn = n;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; enb = 1'b1; clr_err = 1'b0; dp = '0; dn = '0;
        #2;
        total++; if (RxElecIdle !== 4'hF) $display("FAIL reset_idle: got %h expected %h", RxElecIdle, 4'hF); else passed++;
        total++; if ({salida, valido} !== 8'h00) $display("FAIL reset_out: got %h expected %h", {salida, valido}, 8'h00); else passed++;
        total++; if (err_cnt !== 32'h0) $display("FAIL reset_err: got %h expected %h", err_cnt, 32'h0); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire;
        cyc(4'b0001, 4'b0000);
        total++; if ({RxElecIdle, valido} !== 8'hF0) $display("FAIL acq_first: got %h expected %h", {RxElecIdle, valido}, 8'hF0); else passed++;
        cyc(4'b0000, 4'b0001);
        total++; if ({RxElecIdle, valido, salida} !== 12'hE10) $display("FAIL acq_second: got %h expected %h", {RxElecIdle, valido, salida}, 12'hE10); else passed++;
        cyc(4'b0001, 4'b0000);
        total++; if ({RxElecIdle, valido, salida} !== 12'hE11) $display("FAIL acq_third: got %h expected %h", {RxElecIdle, valido, salida}, 12'hE11); else passed++;
    endtask

    task automatic test_glitch;
        cyc(4'b0011, 4'b0000);
        cyc(4'b0011, 4'b0000);
        total++; if ({RxElecIdle, valido, salida} !== 12'hC33) $display("FAIL gl_acquire: got %h expected %h", {RxElecIdle, valido, salida}, 12'hC33); else passed++;
        for (int k = 0; k < 2; k++) begin
            cyc(4'b0001, 4'b0000);
            total++; if ({RxElecIdle, valido, salida} !== 12'hC13) $display("FAIL gl_hold%0d: got %h expected %h", k, {RxElecIdle, valido, salida}, 12'hC13); else passed++;
        end
        cyc(4'b0011, 4'b0000);
        total++; if ({RxElecIdle, valido} !== 8'hC3) $display("FAIL gl_resume: got %h expected %h", {RxElecIdle, valido}, 8'hC3); else passed++;
        total++; if (err_cnt !== 32'h0000_0100) $display("FAIL gl_err: got %h expected %h", err_cnt, 32'h0000_0100); else passed++;
    endtask

    task automatic test_idle_entry;
        cyc(4'b0111, 4'b0000);
        cyc(4'b0111, 4'b0000);
        total++; if ({RxElecIdle, salida} !== 8'h87) $display("FAIL ie_acquire: got %h expected %h", {RxElecIdle, salida}, 8'h87); else passed++;
        for (int k = 0; k < 3; k++) cyc(4'b0111, 4'b0100);
        total++; if ({RxElecIdle, valido, salida} !== 12'h837) $display("FAIL ie_third: got %h expected %h", {RxElecIdle, valido, salida}, 12'h837); else passed++;
        cyc(4'b0111, 4'b0100);
        total++; if ({RxElecIdle, valido, salida} !== 12'hC33) $display("FAIL ie_fourth: got %h expected %h", {RxElecIdle, valido, salida}, 12'hC33); else passed++;
        total++; if (err_cnt !== 32'h0000_0100) $display("FAIL ie_err: got %h expected %h", err_cnt, 32'h0000_0100); else passed++;
    endtask

    task automatic test_saturation;
        cyc(4'b1111, 4'b0000);
        cyc(4'b1111, 4'b0000);
        total++; if ({RxElecIdle, valido} !== 8'h0F) $display("FAIL sat_acquire: got %h expected %h", {RxElecIdle, valido}, 8'h0F); else passed++;
        cyc(4'b0111, 4'b0000);
        cyc(4'b1111, 4'b0000);
        total++; if (err_cnt !== 32'h0100_0100) $display("FAIL sat_one: got %h expected %h", err_cnt, 32'h0100_0100); else passed++;
        for (int k = 1; k < 255; k++) begin
            cyc(4'b0111, 4'b0000);
            cyc(4'b1111, 4'b0000);
        end
        total++; if (err_cnt !== 32'hFF00_0100) $display("FAIL sat_255: got %h expected %h", err_cnt, 32'hFF00_0100); else passed++;
        cyc(4'b0111, 4'b0000);
        cyc(4'b1111, 4'b0000);
        total++; if (err_cnt !== 32'hFF00_0100) $display("FAIL sat_hold: got %h expected %h", err_cnt, 32'hFF00_0100); else passed++;
        cyc(4'b0111, 4'b0000);
        clr_err = 1'b1;
        cyc(4'b1111, 4'b0000);
        clr_err = 1'b0;
        total++; if (err_cnt !== 32'h0) $display("FAIL sat_clr: got %h expected %h", err_cnt, 32'h0); else passed++;
        total++; if ({RxElecIdle, valido} !== 8'h0F) $display("FAIL sat_active: got %h expected %h", {RxElecIdle, valido}, 8'h0F); else passed++;
    endtask

    task automatic test_enable;
        cyc(4'b1110, 4'b0000);
        cyc(4'b1111, 4'b0000);
        total++; if (err_cnt !== 32'h0000_0001) $display("FAIL en_pre_err: got %h expected %h", err_cnt, 32'h0000_0001); else passed++;
        enb = 1'b0;
        cyc(4'b1111, 4'b0000);
        enb = 1'b1;
        total++; if ({RxElecIdle, valido, salida} !== 12'hF00) $display("FAIL en_off: got %h expected %h", {RxElecIdle, valido, salida}, 12'hF00); else passed++;
        total++; if (err_cnt !== 32'h0000_0001) $display("FAIL en_err_hold: got %h expected %h", err_cnt, 32'h0000_0001); else passed++;
        cyc(4'b1111, 4'b0000);
        total++; if ({RxElecIdle, valido} !== 8'hF0) $display("FAIL en_reacq1: got %h expected %h", {RxElecIdle, valido}, 8'hF0); else passed++;
        cyc(4'b1111, 4'b0000);
        total++; if ({RxElecIdle, valido, salida} !== 12'h0FF) $display("FAIL en_reacq2: got %h expected %h", {RxElecIdle, valido, salida}, 12'h0FF); else passed++;
        total++; if (err_cnt !== 32'h0000_0001) $display("FAIL en_err_final: got %h expected %h", err_cnt, 32'h0000_0001); else passed++;
    endtask

    task automatic test_async_reset;
        #3;
        rst = 1'b0;
        #1;
        total++; if ({RxElecIdle, valido, salida} !== 12'hF00) $display("FAIL ar_out: got %h expected %h", {RxElecIdle, valido, salida}, 12'hF00); else passed++;
        total++; if (err_cnt !== 32'h0) $display("FAIL ar_err: got %h expected %h", err_cnt, 32'h0); else passed++;
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b1111, 4'b0000);
        total++; if ({RxElecIdle, valido} !== 8'hF0) $display("FAIL ar_first: got %h expected %h", {RxElecIdle, valido}, 8'hF0); else passed++;
        cyc(4'b1010, 4'b0101);
        total++; if ({RxElecIdle, valido, salida} !== 12'h0FA) $display("FAIL ar_second: got %h expected %h", {RxElecIdle, valido, salida}, 12'h0FA); else passed++;
    endtask

    initial begin
        test_reset;
        test_acquire;
        test_glitch;
        test_idle_entry;
        test_saturation;
        test_enable;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/receptor_diferencial_n.md
RECEPTOR_DIFERENCIAL_N -- requirements
Module: receptor_diferencial_n

Interface
REQ-001 Parameter LANES, default 4: number of independent differential receive lanes (1..16).
REQ-002 Parameter IDLE_CYCLES, default 4: consecutive non-differential samples required to enter electrical idle (2..255).
REQ-003 Parameter EXIT_CYCLES, default 2: consecutive valid differential samples required to leave electrical idle (1..255).
REQ-004 Parameter ERR_W, default 8: width of each per-lane glitch counter.
REQ-005 Port clk  input  1  receive clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset; asynchronous, active-low.
REQ-007 Port enb  input  1  global receive enable; 0 forces every lane to IDLE.
REQ-008 Port clr_err  input  1  synchronous clear of all glitch counters.
REQ-009 Port dp  input  LANES  D+ per lane.
REQ-010 Port dn  input  LANES  D- per lane.
REQ-011 Port salida  output  LANES  recovered serial bit per lane, registered.
REQ-012 Port valido  output  LANES  1 when salida holds a bit sampled this cycle.
REQ-013 Port RxElecIdle  output  LANES  1 while the lane is in IDLE.
REQ-014 Port err_cnt  output  LANES*ERR_W  per-lane glitch count; lane i occupies bits [i*ERR_W +: ERR_W].

Function
REQ-015 A sample of lane i SHALL be differential-valid when dp[i] != dn[i]; its data bit SHALL be dp[i]; dp[i] == dn[i] (00 or 11) SHALL be non-differential.
REQ-016 Each lane SHALL run an independent two-state FSM: IDLE, ACTIVE.
REQ-017 IDLE -> ACTIVE after EXIT_CYCLES consecutive differential-valid samples; any non-differential sample in IDLE SHALL zero the exit run counter.
REQ-018 ACTIVE -> IDLE after IDLE_CYCLES consecutive non-differential samples; any differential-valid sample SHALL zero the idle run counter.
REQ-019 In IDLE: salida=0, valido=0, RxElecIdle=1.
REQ-020 In ACTIVE: a differential-valid sample SHALL drive salida=dp, valido=1 one cycle later (latency 1 clk from sample); a non-differential sample SHALL hold salida and drive valido=0.
REQ-021 RxElecIdle SHALL deassert on the same edge that first drives valido=1 (the EXIT_CYCLES-th valid sample is delivered as data) and assert on the edge of the IDLE_CYCLES-th non-differential sample.
REQ-022 In ACTIVE, a non-differential run of length 1..IDLE_CYCLES-1 terminated by a valid sample SHALL increment that lane's err_cnt by exactly 1 at termination.
REQ-023 err_cnt SHALL saturate at 2^ERR_W-1; clr_err SHALL zero all lanes and win over a simultaneous increment.
REQ-024 enb=0 SHALL, on the next edge, force all lanes to IDLE and zero run counters; err_cnt SHALL hold; re-enable SHALL require the full EXIT_CYCLES sequence.
REQ-025 Lanes SHALL not interact; each lane's behaviour SHALL be identical to a LANES=1 instance fed the same dp/dn.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) set every lane to IDLE: salida=0, valido=0, RxElecIdle=all ones, err_cnt=0, run counters=0, synchronizer flops (if present)=0.
REQ-027 Reset asserted mid-operation SHALL discard any in-progress run; first post-reset edge SHALL sample normally.

Configuration
REQ-028 Macro RX_SYNC_EN defined: dp and dn SHALL each pass a 2-flop synchronizer before classification; total latency sample-to-salida = 3 clk.
REQ-029 RX_SYNC_EN undefined: dp/dn classified directly; latency 1 clk; all other behaviour unchanged.

Verification (LANES=4, IDLE_CYCLES=4, EXIT_CYCLES=2, ERR_W=8, RX_SYNC_EN undefined)
REQ-030 Reset release, lane0 dp/dn = 10,01,10 -> RxElecIdle[0] falls after 2nd sample, salida[0]=0 then 1 with valido=1; other lanes stay idle.
REQ-031 Lane1 ACTIVE, drive 00 for 2 cycles then 10 -> valido[1]=0 two cycles, salida held, err_cnt[1] 0->1, no idle entry.
REQ-032 Lane2 ACTIVE, drive 11 for 4 cycles -> RxElecIdle[2]=1 on 4th, salida[2]=0, err_cnt[2] unchanged.
REQ-033 Force 255 glitches on lane3 then one more -> err_cnt[3]=255; clr_err with simultaneous glitch end -> 0.
REQ-034 All lanes ACTIVE, enb=0 one cycle then 1 -> all RxElecIdle=1, reacquire after 2 valid samples; err_cnt held.
REQ-035 rst=0 between clock edges mid-stream -> outputs reset immediately without a clock edge; repeat REQ-030 with RX_SYNC_EN defined -> first valido at 3rd cycle after 2nd valid sample.
